// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C sequencer: runs START/STOP/WRITE/READ as four quarter phases,
// drives open-drain SCL/SDA enables, honours clock stretching, flags arbitration loss.
module i2c_bit_ctrl #(
  parameter int QDIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic       cmd_din,
  output logic       done,
  output logic       dout,
  output logic       arb_lost,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);
  localparam int CW = $clog2(QDIV);
  localparam logic [CW-1:0] CMAX = CW'(QDIV - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PH_A = 3'd1;
  localparam logic [2:0] PH_B = 3'd2;
  localparam logic [2:0] PH_C = 3'd3;
  localparam logic [2:0] PH_D = 3'd4;

  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_STOP  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_READ  = 2'b11;

  logic [2:0]    state, nxt;
  logic [1:0]    cmd_q;
  logic          din_q;
  logic [CW-1:0] count;
  logic          in_phase, stall, tick, arb_hit;

  // {scl_oe, sda_oe} for a command in a given phase; 1 pulls the line low
  function automatic logic [1:0] levels(input logic [1:0] c, input logic d,
                                        input logic [2:0] ph);
    logic scl_low;
    logic [1:0] r;
    scl_low = (ph == PH_A) || (ph == PH_D);
    r = 2'b00;
    case (c)
      C_START: case (ph)
        PH_A:    r = 2'b10;
        PH_B:    r = 2'b00;
        PH_C:    r = 2'b01;
        default: r = 2'b11;
      endcase
      C_STOP: case (ph)
        PH_A:    r = 2'b11;
        PH_B:    r = 2'b01;
        default: r = 2'b00;
      endcase
      C_WRITE: r = {scl_low, ~d};
      default: r = {scl_low, 1'b0};
    endcase
    return r;
  endfunction

  assign in_phase  = (state != IDLE);
  // a slave holding SCL low while we release it freezes the quarter counter
  assign stall     = in_phase & ~scl_oe & ~scl_i;
  assign tick      = in_phase & ~stall & (count == CMAX);
  assign arb_hit   = (state == PH_B) & (cmd_q == C_WRITE) & din_q & ~sda_i;
  assign nxt       = state + 3'd1;
  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cmd_q    <= C_START;
      din_q    <= 1'b0;
      count    <= '0;
      done     <= 1'b0;
      dout     <= 1'b0;
      arb_lost <= 1'b0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
    end else begin
      done     <= 1'b0;
      arb_lost <= 1'b0;
      if (state == IDLE) begin
        count <= '0;
        if (cmd_valid) begin
          cmd_q            <= cmd;
          din_q            <= cmd_din;
          state            <= PH_A;
          {scl_oe, sda_oe} <= levels(cmd, cmd_din, PH_A);
        end
      end else if (tick) begin
        count <= '0;
        if (arb_hit) begin
          arb_lost <= 1'b1;
          state    <= IDLE;
          scl_oe   <= 1'b0;
          sda_oe   <= 1'b0;
        end else begin
          if ((state == PH_B) && (cmd_q == C_READ)) dout <= sda_i;
          // line levels are left at the PH_D values when returning to IDLE
          if (state == PH_D) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            state            <= nxt;
            {scl_oe, sda_oe} <= levels(cmd_q, din_q, nxt);
          end
        end
      end else if (!stall) begin
        count <= count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Directed bench for i2c_bit_ctrl with QDIV=4 (16-cycle bit) and a simple
// open-drain bus model with a stretch/drive-low override.
module tb_i2c_bit_ctrl;
  localparam int QDIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd = 2'b00;
  logic       cmd_din = 1'b0;
  logic       done, dout, arb_lost, busy;
  logic       scl_i, sda_i, scl_oe, sda_oe;
  logic       stretch = 1'b0;
  logic       sda_ext = 1'b1;

  int n_chk = 0;
  int n_fail = 0;

  // per-command observations
  int r_n, r_sda, r_first, r_scl_first, r_frz;
  bit r_done, r_arb, r_rst;

  assign scl_i = ~scl_oe & ~stretch;
  assign sda_i = ~sda_oe & sda_ext;

  i2c_bit_ctrl #(.QDIV(QDIV)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_din(cmd_din), .done(done), .dout(dout), .arb_lost(arb_lost),
    .busy(busy), .scl_i(scl_i), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Issue one command; starts and ends #1 after a posedge. k counts cycles
  // from the accept edge (k=1 is the first PH_A cycle).
  task automatic run_cmd(input logic [1:0] c, input logic d,
                         input int s_at, input int s_len, input int rst_at);
    cmd_valid = 1'b1; cmd = c; cmd_din = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd = ~c; cmd_din = ~d;
    r_n = 0; r_sda = 0; r_first = 0; r_scl_first = 0; r_frz = -1;
    r_done = 0; r_arb = 0; r_rst = 0;
    for (int k = 1; k <= 200; k++) begin
      r_n = k;
      stretch = (k >= s_at) && (k < s_at + s_len);
      if (k == rst_at) begin
        rst_n = 1'b0; #1;
        r_rst = 1;
        break;
      end
      if (busy && sda_oe) r_sda++;
      if (sda_oe && r_first == 0) begin r_first = k; r_scl_first = scl_oe; end
      if (k == s_at + s_len - 1) r_frz = dut.count;
      if (done) begin r_done = 1; break; end
      if (arb_lost) begin r_arb = 1; break; end
      @(posedge clk); #1;
    end
    stretch = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", dout, 0);
    chk("rst_arb", arb_lost, 0);
    chk("rst_scl", scl_oe, 0);
    chk("rst_sda", sda_oe, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // START
    run_cmd(2'b00, 1'b0, 0, 0, 0);
    chk("start_lat", r_n, 17);
    chk("start_done", r_done, 1);
    chk("start_sda_rise", r_first, 9);
    chk("start_scl_at_rise", r_scl_first, 0);
    chk("start_ready", cmd_ready, 1);
    @(posedge clk); #1;
    chk("start_done_pulse", done, 0);
    chk("start_idle_scl", scl_oe, 1);
    chk("start_idle_sda", sda_oe, 1);

    // WRITE 0 then WRITE 1 back-to-back
    run_cmd(2'b10, 1'b0, 0, 0, 0);
    chk("w0_lat", r_n, 17);
    chk("w0_sda_cycles", r_sda, 16);
    chk("w0_arb", r_arb, 0);
    chk("w0_ready_at_done", cmd_ready, 1);
    run_cmd(2'b10, 1'b1, 0, 0, 0);
    chk("w1_lat", r_n, 17);
    chk("w1_sda_cycles", r_sda, 0);
    chk("w1_arb", r_arb, 0);
    chk("w1_done", r_done, 1);

    // READ 1 then READ 0
    sda_ext = 1'b1;
    run_cmd(2'b11, 1'b0, 0, 0, 0);
    chk("r1_lat", r_n, 17);
    chk("r1_dout", dout, 1);
    chk("r1_sda_cycles", r_sda, 0);
    sda_ext = 1'b0;
    run_cmd(2'b11, 1'b1, 0, 0, 0);
    chk("r0_lat", r_n, 17);
    chk("r0_dout", dout, 0);
    sda_ext = 1'b1;

    // READ with 10-cycle stretch at PH_B entry
    run_cmd(2'b11, 1'b0, 5, 10, 0);
    chk("str_lat", r_n, 27);
    chk("str_cnt_frozen", r_frz, 0);
    chk("str_dout", dout, 1);

    // WRITE 1 losing arbitration
    sda_ext = 1'b0;
    run_cmd(2'b10, 1'b1, 0, 0, 0);
    chk("arb_seen", r_arb, 1);
    chk("arb_at", r_n, 9);
    chk("arb_no_done", done, 0);
    chk("arb_scl", scl_oe, 0);
    chk("arb_sda", sda_oe, 0);
    chk("arb_ready", cmd_ready, 1);
    @(posedge clk); #1;
    chk("arb_pulse", arb_lost, 0);
    chk("arb_no_late_done", done, 0);
    sda_ext = 1'b1;

    // reset during PH_C of a STOP, then a clean START
    run_cmd(2'b01, 1'b0, 0, 0, 10);
    chk("mid_rst_hit", r_rst, 1);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_scl", scl_oe, 0);
    chk("mid_rst_sda", sda_oe, 0);
    chk("mid_rst_dout", dout, 0);
    @(posedge clk); #1;
    chk("mid_rst_no_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_cmd(2'b00, 1'b0, 0, 0, 0);
    chk("post_rst_start_lat", r_n, 17);
    chk("post_rst_start_done", r_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_bit_ctrl.md
# i2c_bit_ctrl

Bit-level I2C sequencer that issues START, STOP, WRITE-bit and READ-bit bus conditions. It divides each bit period into four quarter phases using an internal quarter-period tick counter. It drives the open-drain SCL/SDA enables and samples SDA. It sits between the byte-level I2C master FSM, which issues one command per bit, and the pad-level open-drain buffers. It supports clock stretching and reports arbitration loss.

## Interface
- QDIV, 250: clk cycles per quarter phase; must be ≥ 2; one bit period = 4·QDIV cycles (100 kHz SCL at 100 MHz clk).
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block is idle and accepts a command.
- cmd  in  2  00=START, 01=STOP, 10=WRITE, 11=READ.
- cmd_din  in  1  bit to transmit for WRITE; ignored otherwise.
- done  out  1  one-cycle pulse when a command completes.
- dout  out  1  bit sampled by the last completed READ.
- arb_lost  out  1  one-cycle pulse when arbitration is lost during a WRITE.
- busy  out  1  command in progress (not IDLE).
- scl_i, sda_i  in  1  synchronized bus line levels.
- scl_oe, sda_oe  out  1  1 = pull line low, 0 = release line.

## Operation
- States: IDLE, PH_A, PH_B, PH_C, PH_D.
- Accept: `cmd_valid & cmd_ready` in IDLE latches cmd and cmd_din, then moves to PH_A.
- Phase progression: each phase lasts until a tick, then moves to the next phase.
  - PH_A → PH_B → PH_C → PH_D on successive ticks.
  - The tick in PH_D moves to IDLE.
- Quarter counter:
  - Width $clog2(QDIV); counts 0..QDIV-1.
  - tick = (count == QDIV-1); count wraps to 0 on tick.
  - count is held at 0 in IDLE.
- Line levels per phase, listed as (scl released?, sda value) for A/B/C/D:
  - START: A (scl low, sda rel), B (scl rel, sda rel), C (scl rel, sda low), D (scl low, sda low).
  - STOP: A (scl low, sda low), B (scl rel, sda low), C (scl rel, sda rel), D (scl rel, sda rel).
  - WRITE: scl low, rel, rel, low across A/B/C/D; sda = released if cmd_din=1, low if cmd_din=0, in all phases.
  - READ: same scl pattern as WRITE; sda released in all phases.
- Clock stretching: while scl_oe=0 and scl_i=0, the counter holds its value and no tick occurs. The counter resumes the cycle after scl_i returns to 1.
- READ sampling: sda_i is captured into dout on the tick ending PH_B. dout holds until the next READ sample.
- Arbitration:
  - Applies to WRITE with cmd_din=1.
  - If sda_i=0 at the PH_B tick: pulse arb_lost, release scl_oe and sda_oe, and go to IDLE without asserting done.
- IDLE outputs:
  - After START, WRITE or READ: hold the PH_D levels (SCL low, bus owned).
  - After STOP, arbitration loss or reset: both lines released.
- cmd_valid while not ready is ignored and is not queued. cmd and cmd_din are sampled only at accept.

## Timing
- Reset values: cmd_ready=1, done=0, dout=0, arb_lost=0, busy=0, scl_oe=0, sda_oe=0, state IDLE, count=0.
- Latency without stretching:
  - Accept at edge t0; PH_A occupies cycles t0+1..t0+QDIV.
  - done=1 and cmd_ready=1 in cycle t0+4·QDIV+1.
  - A new command may be accepted in that same cycle (back-to-back).
- Stretching adds exactly the number of cycles during which (scl_oe=0 & scl_i=0) while in a phase.
- busy = ~cmd_ready at all times.
- done and arb_lost are mutually exclusive and never assert in the same cycle.
- Reset asserted mid-command: state returns to IDLE immediately (asynchronously), both lines are released, and no done pulse is issued.
- Outputs are registered: scl_oe and sda_oe change only on clk edges, one cycle after a state change at most.

## Test plan
- Reset, then START (QDIV=4) → done pulses 17 cycles after accept; sda_oe rises in PH_C while scl_oe=0; scl_oe=1 in IDLE afterwards.
- WRITE din=0 then din=1, back-to-back → cmd_ready and accept in the same cycle as done; sda_oe=1 for the full first bit and 0 for the full second bit; no arb_lost.
- READ with sda_i=1, then READ with sda_i=0 at the PH_B tick → dout=1 after the first done, dout=0 after the second.
- Stretch: hold scl_i=0 for 10 cycles at PH_B entry during a READ → done is delayed by exactly 10 cycles; counter value frozen during the stretch.
- WRITE din=1 with sda_i forced 0 → arb_lost pulses once at the PH_B tick; scl_oe=0, sda_oe=0; no done; cmd_ready=1 the next cycle.
- Assert rst_n low during PH_C of a STOP → all outputs at reset values immediately; a subsequent START completes normally.
